// File: rtl/ntable_arb.sv
// Nametable RAM arbiter: the renderer owns the RAM while visible, and queued
// loader writes drain through a 4-entry FIFO only during blanking.
module ntable_arb #(
  parameter int C_MEMW = 8,
  parameter int C_AW   = 10,
  parameter int C_FLOG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              visible,
  input  logic [C_AW-1:0]   ppu_addr,
  output logic [C_MEMW-1:0] ppu_data,
  input  logic              wr_req,
  input  logic [C_AW-1:0]   wr_addr,
  input  logic [C_MEMW-1:0] wr_data,
  output logic              wr_ack,
  output logic [C_FLOG:0]   fifo_cnt,
  output logic              ovf,
  output logic [C_AW-1:0]   mem_addr,
  output logic              mem_we,
  output logic [C_MEMW-1:0] mem_din,
  input  logic [C_MEMW-1:0] mem_dout
);

  localparam int DEPTH = 1 << C_FLOG;
  localparam logic [C_FLOG:0] FULL = (C_FLOG + 1)'(DEPTH);

  logic [C_AW-1:0]   addr_q [DEPTH];
  logic [C_MEMW-1:0] data_q [DEPTH];
  logic [C_FLOG-1:0] wr_ptr;
  logic [C_FLOG-1:0] rd_ptr;
  logic [C_FLOG:0]   cnt;
  logic              ovf_q;

  logic empty;
  logic full;
  logic pop;
  logic push;

  // Handshake: the loader holds wr_req/wr_addr/wr_data stable until wr_ack;
  // every cycle with wr_ack=1 takes exactly one write. A full FIFO still
  // accepts when an entry retires in the same cycle.
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL);
  assign pop   = !rst && !visible && !empty;
  assign push  = !rst && wr_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (wr_req && !push) ovf_q <= 1'b1;
    end
  end

  // Storage carries no reset; entries are only meaningful below cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= wr_addr;
      data_q[wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    mem_we   = pop;
    mem_addr = pop ? addr_q[rd_ptr] : ppu_addr;
    mem_din  = empty ? '0 : data_q[rd_ptr];
  end

  assign wr_ack   = push;
  assign fifo_cnt = cnt;
  assign ovf      = ovf_q;
  assign ppu_data = mem_dout;

endmodule

// File: tb/tb_ntable_arb.sv
// Bench for ntable_arb: directed vector table for the corner cases, then a
// randomized run checked against a queue-based model of the write scheduler.
module tb_ntable_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       visible;
  logic [9:0] ppu_addr;
  logic [7:0] ppu_data;
  logic       wr_req;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic [2:0] fifo_cnt;
  logic       ovf;
  logic [9:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  always #5 clk = ~clk;

  ntable_arb dut (
    .clk      (clk),
    .rst      (rst),
    .visible  (visible),
    .ppu_addr (ppu_addr),
    .ppu_data (ppu_data),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .fifo_cnt (fifo_cnt),
    .ovf      (ovf),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // Single-port synchronous RAM, read data registered (old data on a write).
  logic [7:0] ram [1024];
  logic       ram_init;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'(i) ^ 8'h5A;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, vis, req;
    logic [9:0] waddr;
    logic [7:0] wdata;
    logic [9:0] paddr;
    logic       ack, we;
    logic [9:0] maddr;
    logic [7:0] din;
    logic [2:0] cnt;
    logic       ovf;
    logic       chk_st;
    logic       chk_pd;
    logic [7:0] pd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic q, input logic [9:0] wa,
                     input logic [7:0] wd, input logic [9:0] pa, input logic a, input logic w,
                     input logic [9:0] ma, input logic [7:0] di, input logic [2:0] c,
                     input logic o, input logic cs, input logic cp, input logic [7:0] pd);
    vec_t e;
    e.rst = r; e.vis = v; e.req = q; e.waddr = wa; e.wdata = wd; e.paddr = pa;
    e.ack = a; e.we = w; e.maddr = ma; e.din = di; e.cnt = c; e.ovf = o;
    e.chk_st = cs; e.chk_pd = cp; e.pd = pd;
    vecs.push_back(e);
  endtask

  // Reference model: pending writes as {addr, data} in arrival order.
  logic [17:0] exp_q[$];
  logic [7:0]  exp_ram [1024];
  logic        m_ovf;

  task automatic build_table();
    // reset, then first request accepted immediately
    add(1,1,0, 10'h000,8'h00, 10'h000, 0,0,10'h000,8'h00, 3'd0,0,0, 0,8'h00);
    add(1,1,0, 10'h000,8'h00, 10'h000, 0,0,10'h000,8'h00, 3'd0,0,1, 0,8'h00);
    // blanking write and readback
    add(0,0,1, 10'h041,8'hA5, 10'h100, 1,0,10'h100,8'h00, 3'd0,0,1, 0,8'h00);
    add(0,0,0, 10'h000,8'h00, 10'h100, 0,1,10'h041,8'hA5, 3'd1,0,1, 0,8'h00);
    add(0,1,0, 10'h000,8'h00, 10'h041, 0,0,10'h041,8'h00, 3'd0,0,1, 0,8'h00);
    add(0,1,0, 10'h000,8'h00, 10'h041, 0,0,10'h041,8'h00, 3'd0,0,1, 1,8'hA5);
    // visible hold-off, overflow, then 4-cycle drain in order
    for (int i = 0; i < 4; i++)
      add(0,1,1, 10'(10'h010 + i),8'(8'h11 + i), 10'h200, 1,0,10'h200,8'h00, 3'(i),0,1, 0,8'h00);
    add(0,1,1, 10'h014,8'h15, 10'h200, 0,0,10'h200,8'h00, 3'd4,0,1, 0,8'h00);
    add(0,1,0, 10'h000,8'h00, 10'h200, 0,0,10'h200,8'h00, 3'd4,1,1, 0,8'h00);
    for (int i = 0; i < 4; i++)
      add(0,0,0, 10'h000,8'h00, 10'h200, 0,1,10'(10'h010 + i),8'(8'h11 + i), 3'(4 - i),1,1, 0,8'h00);
    add(0,0,0, 10'h000,8'h00, 10'h200, 0,0,10'h200,8'h00, 3'd0,1,1, 0,8'h00);
    add(1,1,0, 10'h000,8'h00, 10'h200, 0,0,10'h200,8'h00, 3'd0,1,1, 0,8'h00);
    add(0,1,0, 10'h000,8'h00, 10'h200, 0,0,10'h200,8'h00, 3'd0,0,1, 0,8'h00);
    // full FIFO with simultaneous pop accepts without overflow
    for (int i = 0; i < 4; i++)
      add(0,1,1, 10'(10'h020 + i),8'(8'h21 + i), 10'h200, 1,0,10'h200,8'h00, 3'(i),0,1, 0,8'h00);
    add(0,0,1, 10'h030,8'h31, 10'h200, 1,1,10'h020,8'h21, 3'd4,0,1, 0,8'h00);
    add(0,1,0, 10'h000,8'h00, 10'h200, 0,0,10'h200,8'h00, 3'd4,0,1, 0,8'h00);
    // single-cycle blanking gaps retire one entry each
    add(0,0,0, 10'h000,8'h00, 10'h200, 0,1,10'h021,8'h22, 3'd4,0,1, 0,8'h00);
    add(0,1,0, 10'h000,8'h00, 10'h2AA, 0,0,10'h2AA,8'h00, 3'd3,0,1, 0,8'h00);
    add(0,0,0, 10'h000,8'h00, 10'h2AA, 0,1,10'h022,8'h23, 3'd3,0,1, 0,8'h00);
    add(0,1,0, 10'h000,8'h00, 10'h155, 0,0,10'h155,8'h00, 3'd2,0,1, 0,8'h00);
    add(0,1,1, 10'h031,8'h32, 10'h155, 1,0,10'h155,8'h00, 3'd2,0,1, 0,8'h00);
    // reset with 3 pending: no write, queue discarded, RAM untouched
    add(1,0,0, 10'h000,8'h00, 10'h300, 0,0,10'h300,8'h00, 3'd3,0,1, 0,8'h00);
    add(0,0,0, 10'h000,8'h00, 10'h300, 0,0,10'h300,8'h00, 3'd0,0,1, 0,8'h00);
    add(0,1,0, 10'h000,8'h00, 10'h023, 0,0,10'h023,8'h00, 3'd0,0,1, 0,8'h00);
    add(0,1,0, 10'h000,8'h00, 10'h030, 0,0,10'h030,8'h00, 3'd0,0,1, 1,8'h79);
    add(0,1,0, 10'h000,8'h00, 10'h031, 0,0,10'h031,8'h00, 3'd0,0,1, 1,8'h6A);
    add(0,1,0, 10'h000,8'h00, 10'h031, 0,0,10'h031,8'h00, 3'd0,0,1, 1,8'h6B);
  endtask

  initial begin
    bit         pend;
    int         vis_left;
    logic       m_pop, m_push, prev_ok;
    logic [9:0] e_maddr, prev_addr;
    logic [7:0] e_din;

    rst = 1'b1; visible = 1'b1; ppu_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    ram_init = 1'b1;
    @(posedge clk); #1;
    ram_init = 1'b0;

    build_table();
    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst; visible = vecs[k].vis; wr_req = vecs[k].req;
      wr_addr = vecs[k].waddr; wr_data = vecs[k].wdata; ppu_addr = vecs[k].paddr;
      #4;
      check($sformatf("row%0d wr_ack", k), 32'(wr_ack), 32'(vecs[k].ack));
      check($sformatf("row%0d mem_we", k), 32'(mem_we), 32'(vecs[k].we));
      check($sformatf("row%0d mem_addr", k), 32'(mem_addr), 32'(vecs[k].maddr));
      if (vecs[k].we) check($sformatf("row%0d mem_din", k), 32'(mem_din), 32'(vecs[k].din));
      if (vecs[k].chk_st) begin
        check($sformatf("row%0d fifo_cnt", k), 32'(fifo_cnt), 32'(vecs[k].cnt));
        check($sformatf("row%0d ovf", k), 32'(ovf), 32'(vecs[k].ovf));
      end
      if (vecs[k].chk_pd) check($sformatf("row%0d ppu_data", k), 32'(ppu_data), 32'(vecs[k].pd));
      @(posedge clk); #1;
    end

    // Randomized phase from a clean reset and a known RAM image.
    rst = 1'b1; wr_req = 1'b0; ram_init = 1'b1;
    @(posedge clk); #1;
    ram_init = 1'b0; rst = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < 1024; i++) exp_ram[i] = 8'(i) ^ 8'h5A;
    pend = 1'b0; vis_left = 0; prev_ok = 1'b0; prev_addr = '0;

    for (int c = 0; c < 3000; c++) begin
      if (vis_left == 0) begin
        visible  = ~visible;
        vis_left = visible ? $urandom_range(1, 20) : $urandom_range(1, 8);
      end
      vis_left--;
      rst = ($urandom_range(0, 299) == 0);
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend    = 1'b1;
        wr_addr = 10'($urandom_range(0, 1023));
        wr_data = 8'($urandom_range(0, 255));
      end
      wr_req   = pend;
      ppu_addr = 10'($urandom_range(0, 1023));

      m_pop   = !rst && !visible && exp_q.size() != 0;
      m_push  = !rst && pend && (exp_q.size() < 4 || m_pop);
      e_maddr = m_pop ? exp_q[0][17:8] : ppu_addr;
      e_din   = (exp_q.size() != 0) ? exp_q[0][7:0] : 8'h00;
      #4;
      check("rnd wr_ack", 32'(wr_ack), 32'(m_push));
      check("rnd mem_we", 32'(mem_we), 32'(m_pop));
      check("rnd mem_addr", 32'(mem_addr), 32'(e_maddr));
      check("rnd mem_din", 32'(mem_din), 32'(e_din));
      check("rnd fifo_cnt", 32'(fifo_cnt), 32'(exp_q.size()));
      check("rnd ovf", 32'(ovf), 32'(m_ovf));
      if (prev_ok) check("rnd ppu_data", 32'(ppu_data), 32'(exp_ram[prev_addr]));
      prev_ok   = !m_pop;
      prev_addr = e_maddr;

      if (rst) begin
        exp_q.delete();
        m_ovf = 1'b0;
      end else begin
        if (m_pop) begin
          exp_ram[exp_q[0][17:8]] = exp_q[0][7:0];
          void'(exp_q.pop_front());
        end
        if (m_push) exp_q.push_back({wr_addr, wr_data});
        if (pend && !m_push) m_ovf = 1'b1;
      end
      if (m_push) pend = 1'b0;
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ntable_arb.md
# ntable_arb

Arbiter and write scheduler for the 1 KiB nametable RAM that feeds the background renderer. The renderer owns the RAM read port unconditionally while `visible` is high. A loader-side requester (UART/CPU loader) pushes nametable writes through a small FIFO with a req/ack handshake. Queued writes are committed to the RAM only while `visible` is low, so writes never corrupt a fetch and the renderer never stalls. The block sits between the VGA sync/ppu pair and the single-port synchronous nametable RAM.

## Interface
- `C_MEMW`, 8: nametable data width.
- `C_AW`, 10: nametable address width (1 KiB).
- `C_FLOG`, 2: log2 of FIFO depth (depth = 4).
- `clk`  in  1: system clock; one VGA pixel per cycle.
- `rst`  in  1: synchronous, active-high reset.
- `visible`  in  1: high while the VGA beam is in the visible area.
- `ppu_addr`  in  C_AW: renderer nametable address ({tile row, tile col}).
- `ppu_data`  out  C_MEMW: nametable data to renderer, equal to `mem_dout`.
- `wr_req`  in  1: loader write request.
- `wr_addr`  in  C_AW: loader write address.
- `wr_data`  in  C_MEMW: loader write data.
- `wr_ack`  out  1: request accepted this cycle (combinational).
- `fifo_cnt`  out  C_FLOG+1: entries pending, 0..4.
- `ovf`  out  1: sticky flag; a request was refused.
- `mem_addr`  out  C_AW: RAM address.
- `mem_we`  out  1: RAM write enable.
- `mem_din`  out  C_MEMW: RAM write data.
- `mem_dout`  in  C_MEMW: RAM read data, registered inside the RAM, 1-cycle latency.

## Operation
- FIFO: 4 entries of {addr, data}, registered storage, write and read pointers of C_FLOG bits each that wrap modulo depth, and a count register `fifo_cnt`.
- `pop` = !visible && fifo_cnt != 0. Exactly one entry retires per pop cycle.
- `push` = wr_req && (fifo_cnt < 4 || pop).
- `wr_ack` = `push`.
- On a simultaneous push and pop, including when the FIFO is full, `fifo_cnt` is unchanged and both pointers advance.
- Refusal: wr_req && !wr_ack sets `ovf` to 1. `ovf` stays 1 until `rst`.
- The loader holds `wr_req`/`wr_addr`/`wr_data` stable until it sees `wr_ack`. Each ack cycle consumes exactly one write.
- RAM mux, all combinational:
  - visible=1: mem_addr=ppu_addr, mem_we=0.
  - visible=0 and pop: mem_addr=head.addr, mem_din=head.data, mem_we=1.
  - visible=0 and FIFO empty: mem_addr=ppu_addr, mem_we=0.
- `mem_din` = head.data whenever the FIFO is non-empty, else 0.
- Writes retire in FIFO order. Two writes to the same address leave the later value in RAM.
- No write bypass: an entry pushed at cycle t is poppable at t+1 at the earliest.
- `ppu_data` = `mem_dout`. A cycle that follows a write cycle returns RAM write-port read data; this is not valid render data, and the renderer ignores it because `visible` is low.

## Timing
- Reset values (cycle after `rst` high): fifo_cnt=0, ovf=0, pointers=0, mem_we=0, wr_ack=wr_req (FIFO empty, so a request is accepted immediately after reset).
- `rst` asserted mid-operation discards all pending entries. No RAM write occurs in the reset cycle: mem_we is forced to 0 while `rst`=1.
- Write latency: ack at t; mem_we asserted at t+1 for that entry if visible=0 at t+1. Otherwise the entry waits for the next cycle with visible=0.
- Drain rate is 1 entry/cycle during blanking, so 4 entries drain in 4 blanking cycles.
- A `visible` rise stops popping in that same cycle. The renderer address reaches the RAM with no dead cycle, and the read data arrives at t+1.
- Sustained loader throughput is limited to the number of blanking cycles per frame. Excess requests back-pressure through `wr_ack`=0.

## Test plan
- Reset: set rst=1 with wr_req=0 -> fifo_cnt=0, ovf=0, mem_we=0. Then rst=0 with wr_req=1 -> wr_ack=1 in the first cycle.
- Blanking write: visible=0, push {0x041,0xA5} -> mem_we=1 one cycle later with mem_addr=0x041, mem_din=0xA5. Reading 0x041 afterwards during visible returns 0xA5 on ppu_data.
- Visible hold-off: visible=1, push 4 entries -> fifo_cnt=4 and mem_we stays 0. A 5th request gets wr_ack=0 and sets ovf=1. Drop visible -> 4 consecutive mem_we cycles in push order.
- Full with simultaneous pop: fifo_cnt=4, visible=0, wr_req=1 -> wr_ack=1, fifo_cnt stays 4, ovf stays 0.
- Visible edge mid-drain: 3 entries queued, visible=0 for exactly 1 cycle -> 1 write retires, fifo_cnt=2, and ppu_addr drives mem_addr on the next visible cycle.
- Reset mid-drain: rst=1 with 3 entries queued -> no further mem_we, fifo_cnt=0, and RAM contents for the pending addresses are unchanged.
